// File: rtl/serial_adder_scheduler_if.sv
// Handshake bundle between two operand requesters, the serial adder scheduler
// and the result consumer.
interface serial_adder_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_sum, res_carry, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_sum, res_carry, res_id,
    input  res_ready
  );
endinterface

// File: rtl/serial_adder_scheduler.sv
// Round-robin scheduler sharing one bit-serial full adder between two requesters;
// operands are added LSB-first, one bit per cycle.
module serial_adder_scheduler #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_adder_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] bit_token;
  logic             carry;
  logic             carry_next;
  logic             sum_bit;
  logic             cur_id;
  logic             last_id;
  logic             grant_id;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic             last_bit;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_carry_q;
  logic             res_id_q;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_id;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign sum_next   = (sum_sh >> 1) | ({{(WIDTH-1){1'b0}}, sum_bit} << (WIDTH-1));
  assign last_bit   = bit_token[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready0 = bus.req0_valid && !grant_id;
        ready1 = bus.req1_valid && grant_id;
        accept = ready0 || ready1;
        if (accept) state_next = ADD;
      end
      ADD:  if (last_bit) state_next = DONE;
      DONE: if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A one-hot token walks up one position per ADD cycle; reaching the top bit marks the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      bit_token   <= '0;
      carry       <= 1'b0;
      cur_id      <= 1'b0;
      last_id     <= 1'b1;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh      <= grant_id ? bus.req1_a : bus.req0_a;
            b_sh      <= grant_id ? bus.req1_b : bus.req0_b;
            sum_sh    <= '0;
            bit_token <= {{(WIDTH-1){1'b0}}, 1'b1};
            carry     <= 1'b0;
            cur_id    <= grant_id;
            last_id   <= grant_id;
          end
        end
        ADD: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          sum_sh    <= sum_next;
          carry     <= carry_next;
          bit_token <= bit_token << 1;
          if (last_bit) begin
            res_sum_q   <= sum_next;
            res_carry_q <= carry_next;
            res_id_q    <= cur_id;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_id     = res_id_q;

endmodule

// File: tb/tb_serial_adder_scheduler.sv
// Directed-vector bench for serial_adder_scheduler with hand-computed results.
module tb_serial_adder_scheduler;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  serial_adder_scheduler_if #(.WIDTH(WIDTH)) bus();

  serial_adder_scheduler #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers operands on the ports in mask, then follows the op through to the result handshake.
  task automatic applyStimulus(input string tag, input logic [1:0] mask,
                               input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1,
                               input logic exp_id, input logic [8:0] exp_res);
    int cycles;
    bus.req0_a = a0;
    bus.req0_b = b0;
    bus.req1_a = a1;
    bus.req1_b = b1;
    bus.req0_valid = mask[0];
    bus.req1_valid = mask[1];
    #1;
    checkOutput({tag, "_ready0"}, 32'(bus.req0_ready), 32'(!exp_id));
    checkOutput({tag, "_ready1"}, 32'(bus.req1_ready), 32'(exp_id));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = ~a0;
    bus.req1_a = ~a1;
    cycles = 0;
    while (!bus.res_valid && cycles < 3 * WIDTH) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
    checkOutput({tag, "_result"}, 32'({bus.res_carry, bus.res_sum}), 32'(exp_res));
    checkOutput({tag, "_id"}, 32'(bus.res_id), 32'(exp_id));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    int        cycles;
    logic      seen;
    logic      port;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] rexp;

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("reset_sum", 32'(bus.res_sum), 32'd0);
    checkOutput("reset_carry", 32'(bus.res_carry), 32'd0);
    checkOutput("reset_id", 32'(bus.res_id), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic additions");
    applyStimulus("t1", 2'b01, 8'h5A, 8'h33, 8'h00, 8'h00, 1'b0, 9'h08D);
    applyStimulus("t2_wrap", 2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 9'h100);
    applyStimulus("t2_zero", 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h000);
    applyStimulus("t3_pre", 2'b10, 8'h00, 8'h00, 8'h80, 8'h80, 1'b1, 9'h100);

    // Last grant went to req1, so a held tie alternates starting with req0.
    $display("[TB] round-robin under contention");
    bus.req0_a = 8'h01;
    bus.req0_b = 8'h02;
    bus.req1_a = 8'h80;
    bus.req1_b = 8'h80;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      while (!bus.res_valid && cycles < 3 * WIDTH) begin
        @(posedge clk); #1;
        cycles++;
      end
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      checkOutput($sformatf("t3_id%0d", k), 32'(bus.res_id), 32'(k % 2));
      checkOutput($sformatf("t3_res%0d", k), 32'({bus.res_carry, bus.res_sum}),
                  (k % 2 == 1) ? 32'h100 : 32'h003);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] result backpressure");
    bus.req1_a = 8'h7F;
    bus.req1_b = 8'h01;
    bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    cycles = 0;
    while (!bus.res_valid && cycles < 3 * WIDTH) begin
      @(posedge clk); #1;
      cycles++;
    end
    bus.req0_a = 8'h11;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t4_valid%0d", k), 32'(bus.res_valid), 32'd1);
      checkOutput($sformatf("t4_res%0d", k), 32'({bus.res_carry, bus.res_sum}), 32'h080);
      checkOutput($sformatf("t4_id%0d", k), 32'(bus.res_id), 32'd1);
      checkOutput($sformatf("t4_ready%0d", k), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    end
    bus.req0_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput("t4_valid_drop", 32'(bus.res_valid), 32'd0);
    checkOutput("t4_res_held", 32'({bus.res_carry, bus.res_sum}), 32'h080);

    $display("[TB] reset mid-operation");
    bus.req0_a = 8'hAA;
    bus.req0_b = 8'h55;
    bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("t5_rst_sum", 32'(bus.res_sum), 32'd0);
    checkOutput("t5_rst_carry", 32'(bus.res_carry), 32'd0);
    checkOutput("t5_rst_id", 32'(bus.res_id), 32'd0);
    checkOutput("t5_rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    checkOutput("t5_no_result", 32'(seen), 32'd0);
    applyStimulus("t5_tie", 2'b11, 8'h12, 8'h34, 8'h01, 8'h01, 1'b0, 9'h046);

    $display("[TB] mixed operand vectors");
    for (int k = 0; k < 40; k++) begin
      port = 1'($urandom_range(0, 1));
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rexp = {1'b0, ra} + {1'b0, rb};
      if (port)
        applyStimulus($sformatf("r%0d", k), 2'b10, 8'h00, 8'h00, ra, rb, 1'b1, rexp);
      else
        applyStimulus($sformatf("r%0d", k), 2'b01, ra, rb, 8'h00, 8'h00, 1'b0, rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
